rtc_bcd_counter: RTL and testbench

- Parametrised successor to the team's single-digit-pair hour counter.
- Full time-of-day counter (hours:minutes:seconds) with a built-in clock prescaler and BCD digit outputs for the 7-segment display driver.
- Runtime 12/24-hour display mode, validated parallel time load, daily alarm compare, and hourly chime pulse.
- Sits between the board clock and the display mux. All outputs are consistent with the internal time in the same cycle; there is no one-tick display lag.

---
 rtl/rtc_bcd_counter_if.sv | 28 ++
 rtl/rtc_bcd_counter.sv | 155 +++++++++++++++
 tb/tb_rtc_bcd_counter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bcd_counter_if.sv
// Control, load/alarm and display signal bundle for the BCD time-of-day counter.
// The master side drives controls and load/alarm digits; the slave side drives the display.
interface rtc_bcd_counter_if;
    logic       start;
    logic       mode;
    logic       load;
    logic [3:0] ld_hh, ld_hl, ld_mh, ld_ml, ld_sh, ld_sl;
    logic       al_en;
    logic [3:0] al_hh, al_hl, al_mh, al_ml;
    logic [3:0] HH, HL, MH, ML, SH, SL;
    logic       pm;
    logic       sec_tick;
    logic       chime;
    logic       alarm;
    logic       ld_err;

    modport master (
        output start, mode, load, ld_hh, ld_hl, ld_mh, ld_ml, ld_sh, ld_sl,
               al_en, al_hh, al_hl, al_mh, al_ml,
        input  HH, HL, MH, ML, SH, SL, pm, sec_tick, chime, alarm, ld_err
    );

    modport slave (
        input  start, mode, load, ld_hh, ld_hl, ld_mh, ld_ml, ld_sh, ld_sl,
               al_en, al_hh, al_hl, al_mh, al_ml,
        output HH, HL, MH, ML, SH, SL, pm, sec_tick, chime, alarm, ld_err
    );
endinterface

// File: rtl/rtc_bcd_counter.sv
// Hours:minutes:seconds BCD counter with prescaler, validated load, 12/24-hour display,
// daily alarm compare and hourly chime. Display is decoded combinationally from state.
module rtc_bcd_counter #(
    parameter int CLK_DIV = 50000000,
    parameter int DIV_W   = 26
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bcd_counter_if.slave   bus
);

    logic [DIV_W-1:0] div;
    logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
    logic [3:0] n_hr_t, n_hr_u, n_mn_t, n_mn_u, n_sc_t, n_sc_u;
    logic       sec_tick_q, chime_q, alarm_q, ld_err_q;
    logic       tick, ld_ok, al_match;
    logic [4:0] hour_bin, h12;

    assign tick = (div == DIV_W'(CLK_DIV - 1));

    // Time one second ahead of the current state, BCD carry chain with day wrap.
    always_comb begin
        n_hr_t = hr_t;
        n_hr_u = hr_u;
        n_mn_t = mn_t;
        n_mn_u = mn_u;
        n_sc_t = sc_t;
        n_sc_u = sc_u;
        if (sc_u != 4'd9) begin
            n_sc_u = sc_u + 4'd1;
        end else begin
            n_sc_u = 4'd0;
            if (sc_t != 4'd5) begin
                n_sc_t = sc_t + 4'd1;
            end else begin
                n_sc_t = 4'd0;
                if (mn_u != 4'd9) begin
                    n_mn_u = mn_u + 4'd1;
                end else begin
                    n_mn_u = 4'd0;
                    if (mn_t != 4'd5) begin
                        n_mn_t = mn_t + 4'd1;
                    end else begin
                        n_mn_t = 4'd0;
                        if (hr_t == 4'd2 && hr_u == 4'd3) begin
                            n_hr_t = 4'd0;
                            n_hr_u = 4'd0;
                        end else if (hr_u == 4'd9) begin
                            n_hr_t = hr_t + 4'd1;
                            n_hr_u = 4'd0;
                        end else begin
                            n_hr_u = hr_u + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ld_ok = (bus.ld_hl <= 4'd9) && (bus.ld_ml <= 4'd9) && (bus.ld_sl <= 4'd9) &&
                (bus.ld_mh <= 4'd5) && (bus.ld_sh <= 4'd5) &&
                ((bus.ld_hh < 4'd2) || (bus.ld_hh == 4'd2 && bus.ld_hl <= 4'd3));
    end

    // The incremented digits are always valid BCD, so out-of-range alarm digits never match.
    always_comb begin
        al_match = bus.al_en &&
                   (n_hr_t == bus.al_hh) && (n_hr_u == bus.al_hl) &&
                   (n_mn_t == bus.al_mh) && (n_mn_u == bus.al_ml) &&
                   (n_sc_t == 4'd0) && (n_sc_u == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= '0;
            hr_t       <= '0;
            hr_u       <= '0;
            mn_t       <= '0;
            mn_u       <= '0;
            sc_t       <= '0;
            sc_u       <= '0;
            sec_tick_q <= 1'b0;
            chime_q    <= 1'b0;
            alarm_q    <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            chime_q    <= 1'b0;
            alarm_q    <= 1'b0;
            ld_err_q   <= 1'b0;
            if (bus.load && ld_ok) begin
                // An accepted load wins over any tick on the same edge.
                hr_t <= bus.ld_hh;
                hr_u <= bus.ld_hl;
                mn_t <= bus.ld_mh;
                mn_u <= bus.ld_ml;
                sc_t <= bus.ld_sh;
                sc_u <= bus.ld_sl;
                div  <= '0;
            end else begin
                ld_err_q <= bus.load;
                if (!bus.start) begin
                    if (tick) begin
                        div        <= '0;
                        hr_t       <= n_hr_t;
                        hr_u       <= n_hr_u;
                        mn_t       <= n_mn_t;
                        mn_u       <= n_mn_u;
                        sc_t       <= n_sc_t;
                        sc_u       <= n_sc_u;
                        sec_tick_q <= 1'b1;
                        chime_q    <= (n_mn_t == 4'd0) && (n_mn_u == 4'd0) &&
                                      (n_sc_t == 4'd0) && (n_sc_u == 4'd0);
                        alarm_q    <= al_match;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        hour_bin = 5'(hr_t) * 5'd10 + 5'(hr_u);
        h12      = (hour_bin >= 5'd12) ? hour_bin - 5'd12 : hour_bin;
        if (h12 == 5'd0) begin
            h12 = 5'd12;
        end
    end

    always_comb begin
        if (bus.mode) begin
            bus.HH = hr_t;
            bus.HL = hr_u;
        end else if (h12 >= 5'd10) begin
            bus.HH = 4'd1;
            bus.HL = 4'(h12 - 5'd10);
        end else begin
            bus.HH = 4'd0;
            bus.HL = 4'(h12);
        end
    end

    assign bus.MH       = mn_t;
    assign bus.ML       = mn_u;
    assign bus.SH       = sc_t;
    assign bus.SL       = sc_u;
    assign bus.pm       = (hour_bin >= 5'd12);
    assign bus.sec_tick = sec_tick_q;
    assign bus.chime    = chime_q;
    assign bus.alarm    = alarm_q;
    assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Self-checking bench for rtc_bcd_counter: directed scenarios plus randomized traffic,
// checked every cycle against a seconds-of-day arithmetic reference model.
module tb_rtc_bcd_counter;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bcd_counter_if bus();

    rtc_bcd_counter #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: time as seconds since midnight, prescaler as a plain count.
    int m_t, m_div;
    bit m_tick, m_chime, m_alarm, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit time_valid(int hh, int hl, int mh, int ml, int sh, int sl);
        return hh <= 9 && hl <= 9 && mh <= 5 && ml <= 9 && sh <= 5 && sl <= 9 &&
               (hh * 10 + hl) <= 23;
    endfunction

    function automatic logic [23:0] exp_time();
        int h, d, mm, ss;
        h  = m_t / 3600;
        mm = (m_t / 60) % 60;
        ss = m_t % 60;
        d  = bus.mode ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {4'(d / 10), 4'(d % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [23:0] got_time();
        return {bus.HH, bus.HL, bus.MH, bus.ML, bus.SH, bus.SL};
    endfunction

    task automatic model_reset();
        m_t = 0; m_div = 0;
        m_tick = 0; m_chime = 0; m_alarm = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int al_t;
        if (reset) begin
            model_reset();
            return;
        end
        m_tick = 0; m_chime = 0; m_alarm = 0; m_err = 0;
        if (bus.load && time_valid(bus.ld_hh, bus.ld_hl, bus.ld_mh, bus.ld_ml, bus.ld_sh, bus.ld_sl)) begin
            m_t = (bus.ld_hh * 10 + bus.ld_hl) * 3600 + (bus.ld_mh * 10 + bus.ld_ml) * 60 +
                  bus.ld_sh * 10 + bus.ld_sl;
            m_div = 0;
            return;
        end
        m_err = bus.load;
        if (bus.start) return;
        if (m_div == CLK_DIV - 1) begin
            m_div   = 0;
            m_t     = (m_t + 1) % 86400;
            m_tick  = 1;
            m_chime = (m_t % 3600 == 0);
            al_t    = (bus.al_hh * 10 + bus.al_hl) * 3600 + (bus.al_mh * 10 + bus.al_ml) * 60;
            m_alarm = bus.al_en && time_valid(bus.al_hh, bus.al_hl, bus.al_mh, bus.al_ml, 0, 0) &&
                      (m_t == al_t);
        end else begin
            m_div++;
        end
    endtask

    task automatic compare_all();
        check("time", got_time(), exp_time());
        check("flags", {bus.pm, bus.sec_tick, bus.chime, bus.alarm, bus.ld_err},
              {(m_t >= 43200), m_tick, m_chime, m_alarm, m_err});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_ld(input int h, input int m, input int s);
        bus.ld_hh = 4'(h / 10); bus.ld_hl = 4'(h % 10);
        bus.ld_mh = 4'(m / 10); bus.ld_ml = 4'(m % 10);
        bus.ld_sh = 4'(s / 10); bus.ld_sl = 4'(s % 10);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        set_ld(h, m, s);
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic set_alarm(input bit en, input int h, input int m);
        bus.al_en = en;
        bus.al_hh = 4'(h / 10); bus.al_hl = 4'(h % 10);
        bus.al_mh = 4'(m / 10); bus.al_ml = 4'(m % 10);
    endtask

    logic [23:0] saved;

    initial begin
        reset = 1'b1;
        bus.start = 1'b1; bus.mode = 1'b1; bus.load = 1'b0;
        set_ld(0, 0, 0);
        set_alarm(0, 0, 0);
        model_reset();
        repeat (2) cyc();
        check("rst24", got_time(), 24'h000000);
        bus.mode = 1'b0;
        #1;
        check("rst12", got_time(), 24'h120000);
        check("rst_pm", bus.pm, 0);
        bus.mode = 1'b1;

        // Run from reset: ticks on cycles 4, 8, ...
        reset = 1'b0;
        bus.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check("tickpos", bus.sec_tick, (i % 4 == 0));
        end
        repeat (58 * CLK_DIV) cyc();
        check("run60", got_time(), 24'h000100);

        // Rollovers
        do_load(23, 59, 59);
        check("pm_pre", bus.pm, 1);
        repeat (CLK_DIV) cyc();
        check("dayroll", got_time(), 24'h000000);
        check("chime_d", {bus.chime, bus.pm}, 2'b10);
        do_load(11, 59, 59);
        repeat (CLK_DIV) cyc();
        check("noonroll", got_time(), 24'h120000);
        check("chime_n", {bus.chime, bus.pm}, 2'b11);

        // 12-hour display
        bus.mode = 1'b0;
        do_load(0, 30, 0);
        check("h12_0030", {bus.pm, got_time()}, {1'b0, 24'h123000});
        do_load(13, 5, 0);
        check("h12_1305", {bus.pm, got_time()}, {1'b1, 24'h010500});
        bus.mode = 1'b1;
        #1;
        check("h24_1305", got_time(), 24'h130500);

        // Load validation
        saved = got_time();
        do_load(24, 0, 0);
        check("ld24", {bus.ld_err, got_time()}, {1'b1, saved});
        do_load(12, 60, 0);
        check("ld60", bus.ld_err, 1);
        do_load(9, 15, 30);
        check("ld0915", got_time(), 24'h091530);
        for (int i = 1; i <= CLK_DIV; i++) begin
            cyc();
            check("ldtick", bus.sec_tick, (i == CLK_DIV));
        end
        repeat (CLK_DIV - 1) cyc();
        do_load(1, 2, 3);
        check("ld_coinc", {bus.sec_tick, got_time()}, {1'b0, 24'h010203});

        // Alarm
        set_alarm(1, 7, 30);
        do_load(7, 29, 59);
        repeat (CLK_DIV) cyc();
        check("alarm_on", bus.alarm, 1);
        cyc();
        check("alarm_1cy", bus.alarm, 0);
        bus.al_en = 1'b0;
        do_load(7, 29, 59);
        repeat (CLK_DIV) cyc();
        check("alarm_off", bus.alarm, 0);
        bus.al_en = 1'b1;
        do_load(7, 30, 0);
        check("alarm_ld", bus.alarm, 0);

        // Freeze
        bus.start = 1'b1;
        saved = got_time();
        repeat (20) cyc();
        check("freeze", {bus.sec_tick, got_time()}, {1'b0, saved});
        bus.start = 1'b0;

        // Asynchronous reset mid-count
        do_load(5, 6, 7);
        repeat (3) cyc();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst", got_time(), 24'h000000);
        repeat (2) cyc();
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int h, m, s;
            bus.start = ($urandom_range(7) == 0);
            if ($urandom_range(31) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(15) == 0) begin
                h = $urandom_range(23);
                m = ($urandom_range(1) == 0) ? 59 : $urandom_range(59);
                s = 55 + $urandom_range(4);
                set_alarm($urandom_range(3) != 0, (m == 59) ? (h + 1) % 24 : h, (m + 1) % 60);
                if ($urandom_range(3) == 0) begin
                    bus.ld_hh = 4'($urandom_range(15)); bus.ld_hl = 4'($urandom_range(15));
                    bus.ld_mh = 4'($urandom_range(15)); bus.ld_ml = 4'($urandom_range(15));
                    bus.ld_sh = 4'($urandom_range(15)); bus.ld_sl = 4'($urandom_range(15));
                end else begin
                    set_ld(h, m, s);
                end
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            reset = ($urandom_range(499) == 0);
            cyc();
        end
        bus.load = 1'b0;
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
